// File: rtl/psum_acc_ctrl.sv
// psum_acc_ctrl: partial-sum accumulation controller for one PE.
// This block drives the PE's psum scratchpad port. For each output it:
//   1. accepts a job length,
//   2. loads the upstream psum into the scratchpad,
//   3. adds one signed product per cycle with a read-modify-write,
//   4. presents the result downstream and clears the scratchpad.
//
// Ports
//   clk, rst                      clock; synchronous active-high reset
//   cfg_valid/cfg_len/cfg_ready   job length handshake (accepted in IDLE)
//   ipsum_valid/data/ready        upstream psum handshake (accepted in LOAD)
//   prod_valid/data/ready         signed product stream (accepted in ACC)
//   spad_wen/wdata/ren/rdata      scratchpad port; rdata is combinational from ren
//   opsum_valid/data/ready        downstream psum handshake (OUT)
//   busy                          controller not idle
module psum_acc_ctrl #(
  parameter int PSUM_W = 24,
  parameter int PROD_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  input  logic [CNT_W-1:0]  cfg_len,
  output logic              cfg_ready,
  input  logic              ipsum_valid,
  input  logic [PSUM_W-1:0] ipsum_data,
  output logic              ipsum_ready,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod_data,
  output logic              prod_ready,
  output logic              spad_wen,
  output logic [PSUM_W-1:0] spad_wdata,
  output logic              spad_ren,
  input  logic [PSUM_W-1:0] spad_rdata,
  output logic              opsum_valid,
  output logic [PSUM_W-1:0] opsum_data,
  input  logic              opsum_ready,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, LOAD, ACC, OUT} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  len, len_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [PSUM_W-1:0] prod_ext;

  // Sign-extend the product to psum width. The add below wraps mod 2^PSUM_W.
  assign prod_ext = PSUM_W'(signed'(prod_data));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      len   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      len   <= len_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    len_nxt     = len;
    cnt_nxt     = cnt;
    cfg_ready   = 1'b0;
    ipsum_ready = 1'b0;
    prod_ready  = 1'b0;
    spad_wen    = 1'b0;
    spad_wdata  = '0;
    spad_ren    = 1'b0;
    opsum_valid = 1'b0;
    opsum_data  = '0;
    busy        = (state != IDLE);

    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          len_nxt   = cfg_len;
          cnt_nxt   = '0;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        ipsum_ready = 1'b1;
        if (ipsum_valid) begin
          spad_wen   = 1'b1;
          spad_wdata = ipsum_data;
          state_nxt  = (len != '0) ? ACC : OUT;
        end
      end
      ACC: begin
        // Read stays on all through ACC, so the old value is ready on the
        // same cycle a product arrives. This gives one product per cycle.
        prod_ready = 1'b1;
        spad_ren   = 1'b1;
        if (prod_valid) begin
          spad_wen   = 1'b1;
          spad_wdata = spad_rdata + prod_ext;
          // Test cnt against len-1 so cnt never wraps, even for len = max.
          if (cnt == len - CNT_W'(1)) begin
            cnt_nxt   = '0;
            state_nxt = OUT;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      OUT: begin
        spad_ren    = 1'b1;
        opsum_valid = 1'b1;
        opsum_data  = spad_rdata;
        if (opsum_ready) begin
          spad_wen   = 1'b1;   // wdata stays 0: clear the spad for the next job
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // All outputs are forced low during reset, even before the first edge
    // has pulled state back to IDLE.
    if (rst) begin
      cfg_ready   = 1'b0;
      ipsum_ready = 1'b0;
      prod_ready  = 1'b0;
      spad_wen    = 1'b0;
      spad_wdata  = '0;
      spad_ren    = 1'b0;
      opsum_valid = 1'b0;
      opsum_data  = '0;
      busy        = 1'b0;
    end
  end

endmodule

// File: doc/psum_acc_ctrl.md
# psum_acc_ctrl

Partial-sum accumulation controller for one PE: the active side of the PE's 24-bit psum scratchpad port (wen/wdata, ren/rdata). Per output it accepts a job length, loads an incoming psum from the upstream PE, then adds a stream of signed products into the scratchpad at one product per cycle. It then presents the final psum to the downstream PE through a valid/ready handshake and clears the scratchpad.

## Interface
- PSUM_W, 24, psum / scratchpad data width
- PROD_W, 16, signed product width (PROD_W ≤ PSUM_W)
- CNT_W, 8, width of job length and product counter
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; synchronous, active-high
- cfg_valid  in  1  job length offered
- cfg_len  in  CNT_W  products to accumulate for this output (0 allowed)
- cfg_ready  out  1  controller idle, accepts job
- ipsum_valid  in  1  upstream psum offered
- ipsum_data  in  PSUM_W  upstream psum (initial value)
- ipsum_ready  out  1  controller accepts upstream psum
- prod_valid  in  1  product offered
- prod_data  in  PROD_W  signed product (two's complement)
- prod_ready  out  1  controller accepts product
- spad_wen  out  1  scratchpad write enable
- spad_wdata  out  PSUM_W  scratchpad write data
- spad_ren  out  1  scratchpad read enable
- spad_rdata  in  PSUM_W  scratchpad read data, combinational from spad_ren (0 when ren=0)
- opsum_valid  out  1  final psum valid
- opsum_data  out  PSUM_W  final psum
- opsum_ready  in  1  downstream accepts psum
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, LOAD, ACC, OUT. Registers: state, len (CNT_W), cnt (CNT_W).
- IDLE: cfg_ready=1. On cfg_valid: len←cfg_len, cnt←0, go LOAD.
- LOAD: ipsum_ready=1. On ipsum_valid: spad_wen=1, spad_wdata=ipsum_data. Go ACC if len≠0, else go OUT.
- ACC: prod_ready=1, spad_ren=1. On prod_valid:
  - spad_wen=1; spad_wdata = spad_rdata + sign_extend(prod_data) mod 2^PSUM_W (wrap, no saturation, no overflow flag).
  - cnt←cnt+1; when cnt==len−1, go OUT and cnt←0.
  - With prod_valid=0, spad_wen=0 and state holds.
- OUT: spad_ren=1, opsum_valid=1, opsum_data=spad_rdata.
  - On opsum_ready: spad_wen=1, spad_wdata=0 (clear for next job), go IDLE.
  - opsum_data stable while stalled.
- Outputs not listed for a state are 0. opsum_data and spad_wdata are 0 when their qualifier is 0.
- Ready signals are state decodes only and never depend on the matching valid. No combinational valid→ready path.
- Input data is sampled only on its handshake cycle; values at other times are ignored.

## Timing
- Reset: while rst=1, all outputs are forced 0, including cfg_ready, spad_wen and busy. First clock edge with rst=1: state←IDLE, len←0, cnt←0. First cycle after rst drops: cfg_ready=1, everything else 0.
- Reset mid-job (any state): the job is abandoned, with no opsum handshake and no further spad writes. The scratchpad shares rst and clears to 0 itself.
- Throughput: one product per cycle in ACC. Read-modify-write is completed in one cycle because rdata is combinational and the write is registered in the scratchpad.
- Job latency with no stalls, N=cfg_len:
  - N≥1: cfg at cycle 0, ipsum at cycle 1, products at cycles 2..N+1, opsum_valid from cycle N+2.
  - N=0: opsum_valid at cycle 2 with opsum_data = ipsum_data.
- OUT→IDLE costs one cycle, so back-to-back jobs have one cfg_ready bubble after each opsum handshake.
- cfg_len=255 (max): 255 products are accepted. cnt never wraps.

## Test plan
- Basic: cfg_len=3, ipsum=100, products 5, −2, 7 with opsum_ready=1 → opsum_data=110 at cycle 5; the spad is written 0 on the handshake; busy falls the next cycle.
- Wrap and sign: cfg_len=2, ipsum=0xFFFFFF, products +1, −1 (0xFFFF) → intermediate spad value 0x000000, final opsum_data=0xFFFFFF.
- Zero length: cfg_len=0, ipsum=0x123456 → prod_ready never asserts; opsum_data=0x123456 at cycle 2.
- Backpressure and bubbles: random gaps on ipsum_valid and prod_valid, opsum_ready held low for 4 cycles → no spad_wen on idle cycles, opsum_data stable, correct sum 4 products later; cfg_ready low until one cycle after the handshake.
- Reset mid-ACC: rst pulsed after 2 of 5 products → all outputs 0 during rst, cfg_ready=1 next cycle. A fresh job cfg_len=1, ipsum=0, product 9 yields 9.
- Max length: cfg_len=255, ipsum=0, all products +1 → opsum_data=255; exactly 255 prod handshakes.
